// File: rtl/shared_wire_arbiter.sv
// Round-robin arbiter for a shared x/y wire pair with hold-time preemption.
// The owner drives o_x/o_y; ownership changes always pass through one idle TURN cycle.
module shared_wire_arbiter #(
    parameter int N_REQ    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             i_sclk,
    input  logic             i_arst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_x,
    input  logic [N_REQ-1:0] i_y,
    input  logic             i_mode,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_x,
    output logic             o_y,
    output logic             o_z,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   pick;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               timeout_q, timeout_d;
    logic               any_req, owner_req, others_req, hold_full;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return PTR_W'(sum);
    endfunction

    // Scan offsets from the highest down so the last hit is the first requester at/after rr_ptr.
    always_comb begin
        pick = rr_ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[wrap_add(rr_ptr_q, k)]) pick = wrap_add(rr_ptr_q, k);
        end
    end

    assign any_req    = |i_req;
    assign owner_req  = i_req[owner_q];
    assign others_req = |(i_req & ~(N_REQ'(1) << owner_q));
    assign hold_full  = (hold_cnt_q == CNT_W'(MAX_HOLD));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = '0;
        gnt_d      = '0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick;
                    gnt_d      = N_REQ'(1) << pick;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req || (hold_full && others_req)) begin
                    state_d   = ST_TURN;
                    rr_ptr_d  = wrap_add(owner_q, 1);
                    timeout_d = owner_req;
                end else begin
                    gnt_d      = o_gnt;
                    hold_cnt_d = hold_full ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            o_gnt      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            o_gnt      <= gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // o_gnt is one-hot or zero, so masking selects the owner's bit and yields 0 when unowned.
    assign o_x       = |(i_x & o_gnt);
    assign o_y       = |(i_y & o_gnt);
    assign o_z       = i_mode ? (o_x & o_y) : (o_x | o_y);
    assign o_busy    = |o_gnt;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_shared_wire_arbiter.sv
// Self-checking bench for shared_wire_arbiter (N_REQ=2, MAX_HOLD=4): directed scenarios
// plus randomized traffic compared against an ownership-level reference model.
module tb_shared_wire_arbiter;

    localparam int N  = 2;
    localparam int MH = 4;

    logic         i_sclk   = 1'b0;
    logic         i_arst_n = 1'b0;
    logic [N-1:0] i_req    = '0;
    logic [N-1:0] i_x      = '0;
    logic [N-1:0] i_y      = '0;
    logic         i_mode   = 1'b0;
    logic [N-1:0] o_gnt;
    logic         o_x, o_y, o_z, o_busy, o_timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 = none), cycles owned, next round-robin start.
    int m_owner = -1;
    int m_len   = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    always #5 i_sclk = ~i_sclk;

    shared_wire_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .i_sclk   (i_sclk),
        .i_arst_n (i_arst_n),
        .i_req    (i_req),
        .i_x      (i_x),
        .i_y      (i_y),
        .i_mode   (i_mode),
        .o_gnt    (o_gnt),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_z      (o_z),
        .o_busy   (o_busy),
        .o_timeout(o_timeout)
    );

    task automatic model_reset();
        m_owner = -1;
        m_len   = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one rising edge using the requests present before it.
    task automatic model_edge();
        logic [N-1:0] others;
        bit           found;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            others          = i_req;
            others[m_owner] = 1'b0;
            if (!i_req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_len >= MH && others != 0) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_len < MH) begin
                m_len++;
            end
        end else if (i_req != 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && i_req[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_len = 1;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic logic exp_x();
        return (m_owner >= 0) ? i_x[m_owner] : 1'b0;
    endfunction

    function automatic logic exp_y();
        return (m_owner >= 0) ? i_y[m_owner] : 1'b0;
    endfunction

    function automatic logic exp_z();
        return i_mode ? (exp_x() & exp_y()) : (exp_x() | exp_y());
    endfunction

    // Drive inputs at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic mode);
        @(negedge i_sclk);
        i_req  = req;
        i_x    = x;
        i_y    = y;
        i_mode = mode;
        @(posedge i_sclk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_sclk);
        i_arst_n = 1'b0;
        #2;
        model_reset();
        i_arst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0;
        i_mode   = 1'b0;
        #3;
        checks++;
        if (o_gnt !== 2'b00 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b busy=%b timeout=%b, required 00/0/0", o_gnt, o_busy, o_timeout);
        end
        checks++;
        if (o_x !== 1'b0 || o_y !== 1'b0 || o_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_or_wires: x=%b y=%b z=%b, required 0/0/0", o_x, o_y, o_z);
        end
        i_mode = 1'b1;
        i_x    = 2'b11;
        i_y    = 2'b11;
        #1;
        checks++;
        if (o_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_and_z: z=%b, required 0", o_z);
        end
        i_mode = 1'b0;
        i_x    = '0;
        i_y    = '0;
        @(negedge i_sclk);
        model_reset();
        i_arst_n = 1'b1;
    endtask

    task automatic test_basic_grant();
        step(2'b01, 2'b01, 2'b00, 1'b0);
        checks++;
        if (o_gnt !== 2'b01) begin
            errors++;
            $display("FAIL basic_gnt: gnt=%b, required 01", o_gnt);
        end
        checks++;
        if (o_x !== 1'b1 || o_y !== 1'b0 || o_z !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_wires: x=%b y=%b z=%b busy=%b, required 1/0/1/1", o_x, o_y, o_z, o_busy);
        end
        step(2'b00, 2'b01, 2'b00, 1'b0);
        checks++;
        if (o_gnt !== 2'b00 || o_x !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: gnt=%b x=%b timeout=%b, required 00/0/0", o_gnt, o_x, o_timeout);
        end
    endtask

    task automatic test_handover();
        logic [N-1:0] want [3] = '{2'b01, 2'b00, 2'b10};
        logic [N-1:0] reqs [3] = '{2'b11, 2'b10, 2'b10};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(reqs[i], 2'b00, 2'b00, 1'b0);
            checks++;
            if (o_gnt !== want[i]) begin
                errors++;
                $display("FAIL handover_%0d: gnt=%b, required %b", i, o_gnt, want[i]);
            end
        end
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    // Both requesting forever: 4 grant cycles, one gap cycle with the timeout pulse, alternating.
    task automatic test_timeout();
        logic [N-1:0] want_gnt;
        logic         want_to;
        int           pos;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(2'b11, 2'b10, 2'b01, 1'b0);
            pos      = (k - 1) % (MH + 1);
            want_to  = (pos == MH);
            want_gnt = (pos == MH) ? 2'b00 : ((((k - 1) / (MH + 1)) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (o_gnt !== want_gnt || o_timeout !== want_to || o_busy !== (want_gnt != 0)) begin
                errors++;
                $display("FAIL timeout_cycle%0d: gnt=%b timeout=%b busy=%b, required %b/%b/%b",
                         k, o_gnt, o_timeout, o_busy, want_gnt, want_to, want_gnt != 0);
            end
        end
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_hold_alone();
        int bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(2'b01, 2'b01, 2'b01, 1'b0);
            if (o_gnt !== 2'b01 || o_timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_alone: %0d of 20 cycles off (last gnt=%b timeout=%b), required 01/0", bad, o_gnt, o_timeout);
        end
    endtask

    // Continues from the held grant of requester 0.
    task automatic test_reset_mid_grant();
        @(negedge i_sclk);
        i_x = 2'b01;
        #2;
        i_arst_n = 1'b0;
        #1;
        checks++;
        if (o_gnt !== 2'b00 || o_x !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: gnt=%b x=%b busy=%b, required 00/0/0", o_gnt, o_x, o_busy);
        end
        model_reset();
        @(negedge i_sclk);
        i_arst_n = 1'b1;
        step(2'b11, 2'b00, 2'b00, 1'b0);
        checks++;
        if (o_gnt !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_arb: gnt=%b, required 01", o_gnt);
        end
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_and_mode();
        step(2'b00, 2'b11, 2'b11, 1'b1);
        checks++;
        if (o_z !== 1'b0) begin
            errors++;
            $display("FAIL and_idle_z: z=%b, required 0", o_z);
        end
        step(2'b01, 2'b01, 2'b01, 1'b1);
        checks++;
        if (o_z !== 1'b1) begin
            errors++;
            $display("FAIL and_owner_z: z=%b, required 1", o_z);
        end
        step(2'b01, 2'b01, 2'b00, 1'b1);
        checks++;
        if (o_z !== 1'b0 || o_x !== 1'b1) begin
            errors++;
            $display("FAIL and_partial_z: x=%b z=%b, required 1/0", o_x, o_z);
        end
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] req = '0;
        logic [N-1:0] prev_gnt = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            step(req, N'($urandom), N'($urandom), 1'($urandom));
            checks++;
            if (o_gnt !== exp_gnt() || o_timeout !== m_to || o_busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: gnt=%b timeout=%b busy=%b, required %b/%b/%b",
                         k, o_gnt, o_timeout, o_busy, exp_gnt(), m_to, m_owner >= 0);
            end
            checks++;
            if (o_x !== exp_x() || o_y !== exp_y() || o_z !== exp_z()) begin
                errors++;
                $display("FAIL rand_wires@%0d: x=%b y=%b z=%b, required %b/%b/%b",
                         k, o_x, o_y, o_z, exp_x(), exp_y(), exp_z());
            end
            checks++;
            if (prev_gnt != 0 && o_gnt != 0 && prev_gnt !== o_gnt) begin
                errors++;
                $display("FAIL rand_gap@%0d: gnt went %b -> %b, required an all-zero cycle between", k, prev_gnt, o_gnt);
            end
            prev_gnt = o_gnt;
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_handover();
        test_timeout();
        test_hold_alone();
        test_reset_mid_grant();
        test_and_mode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_wire_arbiter.md
SHARED_WIRE_ARBITER -- requirements
Module: shared_wire_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, giving the number of requesters sharing the wire pair (legal 2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the grant cycles before an owner may be preempted (legal 2..255).
REQ-003 The block SHALL have port i_sclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_arst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_req, input, N_REQ bits: per-requester ownership request, level-sensitive.
REQ-006 The block SHALL have port i_x, input, N_REQ bits: per-requester x value.
REQ-007 The block SHALL have port i_y, input, N_REQ bits: per-requester y value.
REQ-008 The block SHALL have port i_mode, input, 1 bit: z combine select (1 = AND, 0 = OR).
REQ-009 The block SHALL have port o_gnt, output, N_REQ bits: registered one-hot grant, all-zero when unowned.
REQ-010 The block SHALL have port o_x, output, 1 bit: shared x, driven by the owner only.
REQ-011 The block SHALL have port o_y, output, 1 bit: shared y, driven by the owner only.
REQ-012 The block SHALL have port o_z, output, 1 bit: combined result of o_x and o_y.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high while o_gnt is non-zero.
REQ-014 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse on forced preemption.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, GRANT and TURN.
REQ-016 In IDLE with any i_req bit high, the block SHALL pick the first requester at or after round-robin pointer rr_ptr (ascending, wrapping), enter GRANT and assert that o_gnt bit on the next edge (1-cycle latency).
REQ-017 In IDLE with i_req all-zero, the block SHALL remain in IDLE with o_gnt all-zero.
REQ-018 The block SHALL load hold counter hold_cnt with 1 on entry to GRANT, increment it each further GRANT cycle and saturate it at MAX_HOLD.
REQ-019 In GRANT, if i_req[owner] is low, the block SHALL enter TURN on the next edge (no timeout pulse).
REQ-020 In GRANT, if hold_cnt equals MAX_HOLD, i_req[owner] is high and any other i_req bit is high, the block SHALL enter TURN and pulse o_timeout for exactly that transition cycle.
REQ-021 In GRANT, if hold_cnt equals MAX_HOLD and no other requester is pending, the block SHALL keep the owner granted indefinitely.
REQ-022 On entering TURN, the block SHALL clear o_gnt to all-zero and set rr_ptr to (owner+1) mod N_REQ.
REQ-023 TURN SHALL last exactly one cycle, then arbitrate as in IDLE using the updated rr_ptr, going to GRANT if any request is pending, else to IDLE.
REQ-024 The block SHALL never grant back-to-back to two owners: at least one all-zero o_gnt cycle SHALL separate any two grants.
REQ-025 o_x and o_y SHALL be combinational selects of i_x[owner] and i_y[owner] while o_gnt is non-zero, and 0 otherwise.
REQ-026 o_z SHALL be combinational: i_mode ? (o_x & o_y) : (o_x | o_y).
REQ-027 o_busy SHALL equal the OR-reduction of o_gnt.
REQ-028 A request that rises in the same cycle another owner releases SHALL be arbitrated in TURN, not lost.
REQ-029 The block SHALL ignore a request that rises and falls while another owner holds the grant; requests are not latched.

Reset
REQ-030 On i_arst_n low, the block SHALL immediately set state = IDLE, o_gnt = 0, rr_ptr = 0, hold_cnt = 0, o_timeout = 0, o_busy = 0, o_x = 0, o_y = 0, with o_z = 0 in OR mode and 0 in AND mode.
REQ-031 Reset asserted mid-grant SHALL drop the grant asynchronously; after release, the first arbitration SHALL start from rr_ptr = 0.

Verification (N_REQ = 2, MAX_HOLD = 4)
REQ-032 Bench SHALL cover: reset release, i_req = 01 at cycle t -> o_gnt = 01 at t+1; i_x[0] = 1, i_y[0] = 0, i_mode = 0 -> o_x = 1, o_y = 0, o_z = 1.
REQ-033 Bench SHALL cover: i_req = 11 in IDLE with rr_ptr = 0 -> o_gnt = 01; drop req0 -> one cycle o_gnt = 00, then o_gnt = 10.
REQ-034 Bench SHALL cover: i_req = 11 held -> o_gnt = 01 for exactly 4 cycles, o_timeout = 1 for one cycle, o_gnt = 00 one cycle, then o_gnt = 10 for 4 cycles, alternating.
REQ-035 Bench SHALL cover: i_req = 01 held alone for 20 cycles -> o_gnt stays 01 and o_timeout stays 0.
REQ-036 Bench SHALL cover: i_arst_n pulsed low during grant -> o_gnt = 00 and o_x = 0 in the same cycle; with i_req = 11 after release -> o_gnt = 01.
REQ-037 Bench SHALL cover: no grant and i_mode = 1 -> o_z = 0; owner i_x = 1, i_y = 1 -> o_z = 1.
